// File: rtl/zigzag_pkg.sv
// zigzag_pkg: shared types and the JPEG zigzag scan table for the zigzag reorder stage.
package zigzag_pkg;
  typedef logic [7:0] coef_t;
  typedef logic [5:0] idx_t;
  typedef struct packed {
    logic  last;
    coef_t data;
  } ent_t;
  localparam idx_t BLK_LAST = 6'd63;
  // ZIGZAG[k] is the raster index of the k-th coefficient in zigzag order
  localparam idx_t ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/sp_ram_8bx64.sv
// sp_ram_8bx64: 64x8 single-port RAM with registered (1-cycle) read.
module sp_ram_8bx64 (
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] mem [64];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/zigzag_ctrl.sv
// zigzag_ctrl: ping-pong raster-to-zigzag reorder with valid/ready on both sides.
module zigzag_ctrl
  import zigzag_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  logic       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  idx_t       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0] full_q, full_d;
  logic       infl_q, infl_last_q, infl_bank_q;
  logic [1:0] cnt_q, cnt_d;
  logic       head_q, head_d;
  ent_t       buf_q [2];
  ent_t       buf_d [2];
  logic       acc, pop, issue;
  idx_t       rd_addr, addr0, addr1;
  coef_t      dout0, dout1;
  assign in_ready  = !rst && !full_q[wr_bank_q];
  assign acc       = in_valid && in_ready;
  assign out_valid = cnt_q != 2'd0;
  assign pop       = out_valid && out_ready;
  // a read lands in the buffer next cycle, so reserve a slot for anything in flight
  assign issue     = full_q[rd_bank_q] && (cnt_q - {1'b0, pop} + {1'b0, infl_q}) < 2'd2;
  assign rd_addr   = ZIGZAG[rd_cnt_q];
  assign addr0     = (!wr_bank_q && !full_q[0]) ? wr_cnt_q : rd_addr;
  assign addr1     = (wr_bank_q && !full_q[1]) ? wr_cnt_q : rd_addr;
  assign out_data  = out_valid ? buf_q[head_q].data : '0;
  assign out_last  = out_valid && buf_q[head_q].last;
  sp_ram_8bx64 bank0 (.clk(clk), .we(acc && !wr_bank_q), .addr(addr0), .din(in_data), .dout(dout0));
  sp_ram_8bx64 bank1 (.clk(clk), .we(acc && wr_bank_q), .addr(addr1), .din(in_data), .dout(dout1));
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;
    buf_d     = buf_q;
    head_d    = head_q ^ pop;
    cnt_d     = cnt_q - {1'b0, pop} + {1'b0, infl_q};
    if (acc) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == BLK_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (issue) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == BLK_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
    if (infl_q) buf_d[head_q ^ cnt_q[0]] = '{last: infl_last_q, data: infl_bank_q ? dout1 : dout0};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      full_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_bank_q <= 1'b0;
      cnt_q       <= '0;
      head_q      <= 1'b0;
      buf_q       <= '{default: '0};
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      infl_q      <= issue;
      infl_last_q <= rd_cnt_q == BLK_LAST;
      infl_bank_q <= rd_bank_q;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      buf_q       <= buf_d;
    end
  end
endmodule
